shift_operand_sequencer: RTL and testbench

Multi-cycle front end that drives the datapath barrel shifter. It accepts a 32-bit data-processing instruction word over a valid/ready handshake and decodes the operand-2 field (rotated immediate, immediate-amount shift or register-amount shift). It fetches Rm and Rs through a one-cycle-latency register-file read port, presents registered data/amount/op to the shifter, and returns operand 2 plus its carry over a valid/ready handshake to the ALU stage.

---
 rtl/shift_operand_sequencer_pkg.sv | 36 +++
 rtl/shift_operand_sequencer_if.sv | 50 +++++
 rtl/shift_operand_sequencer_decode.sv | 38 +++
 rtl/shift_operand_sequencer.sv | 168 ++++++++++++++++
 tb/tb_shift_operand_sequencer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_operand_sequencer_pkg.sv
// Shared definitions for the operand-2 shift sequencer: FSM state encoding,
// barrel-shifter type codes, instruction field positions and the carry-source rule.
package shift_pkg;

    // Sequencer FSM states, in the order an instruction walks through them
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_RM = 3'd1,
        RD_RS = 3'd2,
        LOAD  = 3'd3,
        SHIFT = 3'd4,
        OUT   = 3'd5
    } state_t;

    // Shift type field as presented on shift_op[2:1]
    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Instruction field positions
    localparam int I_BIT         = 25;
    localparam int REG_SHIFT_BIT = 4;

    // Rotated immediates use the register-amount ROR encoding
    localparam logic [2:0] OP_IMM_ROT = {SH_ROR, 1'b1};

    // True when the shifter leaves its carry undefined and the old C flag
    // must pass through instead: a zero amount under register-amount
    // semantics, or LSL #0 under immediate semantics.
    function automatic logic carry_from_flag(input logic [7:0] num,
                                             input logic [2:0] op);
        return (num == 8'd0) && (op[0] || (op == {SH_LSL, 1'b0}));
    endfunction

endpackage

// File: rtl/shift_operand_sequencer_if.sv
// Signal bundle between the sequencer and its neighbours: the instruction
// handshake, the register-file read port, the barrel shifter and the ALU-side
// result handshake.
//
// Handshakes (in_valid/in_ready, out_valid/out_ready): a transfer happens on a
// rising edge where valid and ready are both high. The payload must be stable
// whenever valid is high, and valid stays high until the transfer. Ready does
// not depend on valid.
interface shift_operand_sequencer_if;

    // Instruction input handshake
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        cf_in;

    // Register-file read port, data one cycle after the strobe
    logic        rf_rd_en;
    logic [3:0]  rf_addr;
    logic [31:0] rf_rdata;

    // Barrel shifter operands and result
    logic [31:0] shift_data;
    logic [7:0]  shift_num;
    logic [2:0]  shift_op;
    logic        shift_cf;
    logic [31:0] shift_out;
    logic        shift_carry_in;

    // Operand-2 result handshake
    logic        out_valid;
    logic        out_ready;
    logic [31:0] op2;
    logic        op2_carry;

    // Sequencer side
    modport master (
        input  in_valid, instr, cf_in, rf_rdata, shift_out, shift_carry_in, out_ready,
        output in_ready, rf_rd_en, rf_addr, shift_data, shift_num, shift_op, shift_cf,
               out_valid, op2, op2_carry
    );

    // Environment side: instruction source, register file, shifter, ALU
    modport slave (
        output in_valid, instr, cf_in, rf_rdata, shift_out, shift_carry_in, out_ready,
        input  in_ready, rf_rd_en, rf_addr, shift_data, shift_num, shift_op, shift_cf,
               out_valid, op2, op2_carry
    );

endinterface

// File: rtl/shift_operand_sequencer_decode.sv
// Combinational decode of the operand-2 field: register indices, the
// immediate operand and the shift amount/op known at accept time.
module op2_field_decode
    import shift_pkg::*;
(
    input  logic        imm_bit_i,
    input  logic [11:0] field_i,
    output logic        imm_o,
    output logic        reg_shift_o,
    output logic [3:0]  rm_idx_o,
    output logic [3:0]  rs_idx_o,
    output logic [31:0] imm_data_o,
    output logic [7:0]  num_o,
    output logic [2:0]  op_o
);

    // Split the field; the register-amount case leaves num at 0 until Rs arrives
    always_comb begin
        imm_o       = imm_bit_i;
        reg_shift_o = !imm_bit_i && field_i[REG_SHIFT_BIT];
        rm_idx_o    = field_i[3:0];
        rs_idx_o    = field_i[11:8];
        imm_data_o  = {24'd0, field_i[7:0]};
        num_o       = 8'd0;
        op_o        = 3'd0;
        if (imm_bit_i) begin
            num_o = {3'd0, field_i[11:8], 1'b0};
            op_o  = OP_IMM_ROT;
        end else if (field_i[REG_SHIFT_BIT]) begin
            num_o = 8'd0;
            op_o  = {field_i[6:5], 1'b1};
        end else begin
            num_o = {3'd0, field_i[11:7]};
            op_o  = {field_i[6:5], 1'b0};
        end
    end

endmodule

// File: rtl/shift_operand_sequencer.sv
// Multi-cycle operand-2 sequencer: accepts an instruction, fetches Rm/Rs from
// the register file, holds registered operands steady for the external
// barrel shifter, then offers operand 2 and its carry to the ALU stage.
module shift_operand_sequencer
    import shift_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    shift_operand_sequencer_if.master bus,
    output state_t                    dbg_state_o
);

    state_t      state_q, state_d;

    logic [31:0] data_q, data_d;
    logic [7:0]  num_q, num_d;
    logic [2:0]  op_q, op_d;
    logic        cf_q, cf_d;
    logic [3:0]  rm_q, rm_d;
    logic [3:0]  rs_q, rs_d;
    logic        reg_shift_q, reg_shift_d;
    logic [31:0] op2_q, op2_d;
    logic        op2_carry_q, op2_carry_d;

    logic        dec_imm;
    logic        dec_reg_shift;
    logic [3:0]  dec_rm;
    logic [3:0]  dec_rs;
    logic [31:0] dec_imm_data;
    logic [7:0]  dec_num;
    logic [2:0]  dec_op;

    // Instruction bits outside the operand-2 field play no part here
    logic        unused_instr_bits;
    assign unused_instr_bits = ^{bus.instr[31:26], bus.instr[24:12]};

    op2_field_decode u_decode (
        .imm_bit_i   (bus.instr[I_BIT]),
        .field_i     (bus.instr[11:0]),
        .imm_o       (dec_imm),
        .reg_shift_o (dec_reg_shift),
        .rm_idx_o    (dec_rm),
        .rs_idx_o    (dec_rs),
        .imm_data_o  (dec_imm_data),
        .num_o       (dec_num),
        .op_o        (dec_op)
    );

    // FSM state register; reset abandons any in-flight instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: immediates skip the register reads entirely
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = dec_imm ? SHIFT : RD_RM;
            RD_RM:   state_d = reg_shift_q ? RD_RS : LOAD;
            RD_RS:   state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   state_d = OUT;
            OUT:     if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake readies and the register-file read port
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.rf_rd_en  = 1'b0;
        bus.rf_addr   = 4'd0;
        case (state_q)
            IDLE:  bus.in_ready = 1'b1;
            RD_RM: begin
                bus.rf_rd_en = 1'b1;
                bus.rf_addr  = rm_q;
            end
            RD_RS: begin
                bus.rf_rd_en = 1'b1;
                bus.rf_addr  = rs_q;
            end
            OUT:   bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next values: latch decode at accept, fill in read data as it
    // returns, and capture the shifter result once its inputs have settled
    always_comb begin
        data_d      = data_q;
        num_d       = num_q;
        op_d        = op_q;
        cf_d        = cf_q;
        rm_d        = rm_q;
        rs_d        = rs_q;
        reg_shift_d = reg_shift_q;
        op2_d       = op2_q;
        op2_carry_d = op2_carry_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    cf_d        = bus.cf_in;
                    rm_d        = dec_rm;
                    rs_d        = dec_rs;
                    reg_shift_d = dec_reg_shift;
                    num_d       = dec_num;
                    op_d        = dec_op;
                    data_d      = dec_imm ? dec_imm_data : 32'd0;
                end
            end
            // Rm read issued in RD_RM lands here
            RD_RS: data_d = bus.rf_rdata;
            // Either Rs (amount, low byte only) or Rm lands here
            LOAD: begin
                if (reg_shift_q) begin
                    num_d = bus.rf_rdata[7:0];
                end else begin
                    data_d = bus.rf_rdata;
                end
            end
            SHIFT: begin
                op2_d       = bus.shift_out;
                op2_carry_d = carry_from_flag(num_q, op_q) ? cf_q : bus.shift_carry_in;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= 32'd0;
            num_q       <= 8'd0;
            op_q        <= 3'd0;
            cf_q        <= 1'b0;
            rm_q        <= 4'd0;
            rs_q        <= 4'd0;
            reg_shift_q <= 1'b0;
            op2_q       <= 32'd0;
            op2_carry_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            num_q       <= num_d;
            op_q        <= op_d;
            cf_q        <= cf_d;
            rm_q        <= rm_d;
            rs_q        <= rs_d;
            reg_shift_q <= reg_shift_d;
            op2_q       <= op2_d;
            op2_carry_q <= op2_carry_d;
        end
    end

    assign bus.shift_data = data_q;
    assign bus.shift_num  = num_q;
    assign bus.shift_op   = op_q;
    assign bus.shift_cf   = cf_q;
    assign bus.op2        = op2_q;
    assign bus.op2_carry  = op2_carry_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_shift_operand_sequencer.sv
// Bench for shift_operand_sequencer with a register-file model and a barrel
// shifter model around it, and an architectural operand-2 reference.
module tb_shift_operand_sequencer;
    import shift_pkg::*;

    logic        clk;
    logic        rst;
    state_t      dbg_state;
    int          n_cmp = 0;
    int          n_mis = 0;
    logic [32:0] exp_q[$];
    logic [31:0] regs[16];
    logic [32:0] sh_full;

    shift_operand_sequencer_if ifc();

    shift_operand_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (ifc),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded its time limit");
        $fatal(1, "timeout");
    end

    // ---------------- architectural shift ----------------
    // ARM barrel-shifter result {carry, value}; op[0] selects register-amount rules
    function automatic logic [32:0] arm_shift(input logic [31:0] d, input logic [7:0] amt,
                                              input logic [2:0] op, input logic cf);
        logic [32:0]        r;
        logic signed [31:0] sd;
        int                 n;
        int                 m;
        n  = int'(amt);
        sd = d;
        r  = {cf, d};
        if (!op[0] && n == 0) begin
            case (op[2:1])
                2'b00:   r = {cf, d};
                2'b01:   r = {d[31], 32'd0};
                2'b10:   r = {d[31], {32{d[31]}}};
                default: r = {d[0], cf, d[31:1]};
            endcase
        end else if (n != 0) begin
            case (op[2:1])
                2'b00: begin
                    if (n < 32)       r = {d[32-n], d << n};
                    else if (n == 32) r = {d[0], 32'd0};
                    else              r = 33'd0;
                end
                2'b01: begin
                    if (n < 32)       r = {d[n-1], d >> n};
                    else if (n == 32) r = {d[31], 32'd0};
                    else              r = 33'd0;
                end
                2'b10: begin
                    if (n < 32) r = {d[n-1], 32'(sd >>> n)};
                    else        r = {d[31], {32{d[31]}}};
                end
                default: begin
                    m = n % 32;
                    if (m == 0) r = {d[31], d};
                    else        r = {d[m-1], (d >> m) | (d << (32 - m))};
                end
            endcase
        end
        return r;
    endfunction

    // ---------------- environment models ----------------
    // Register file: one-cycle read latency, junk on the bus when not reading
    always @(posedge clk) begin
        if (ifc.rf_rd_en) ifc.rf_rdata <= regs[ifc.rf_addr];
        else              ifc.rf_rdata <= $urandom;
    end

    // Shifter: where its carry is architecturally undefined it returns the
    // opposite of the flag, so a sequencer that trusts it gets caught
    always_comb begin
        sh_full   = arm_shift(ifc.shift_data, ifc.shift_num, ifc.shift_op, ifc.shift_cf);
        ifc.shift_out = sh_full[31:0];
        if (ifc.shift_num == 8'd0 && (ifc.shift_op[0] || ifc.shift_op == 3'b000))
            ifc.shift_carry_in = ~sh_full[32];
        else
            ifc.shift_carry_in = sh_full[32];
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: operand 2, expected shifter operands and out_valid latency
    task automatic ref_model(input logic [31:0] ins, input logic cf, output logic [32:0] ev,
                             output logic [31:0] d, output logic [7:0] num,
                             output logic [2:0] op, output int lat);
        int          rot;
        logic [31:0] v;
        logic [31:0] res;
        if (ins[25]) begin
            v   = {24'd0, ins[7:0]};
            rot = 2 * int'(ins[11:8]);
            res = (rot == 0) ? v : ((v >> rot) | (v << (32 - rot)));
            ev  = {(rot == 0) ? cf : res[31], res};
            d   = v;
            num = 8'(rot);
            op  = 3'b111;
            lat = 2;
        end else begin
            d = regs[ins[3:0]];
            if (ins[4]) begin
                num = regs[ins[11:8]][7:0];
                op  = {ins[6:5], 1'b1};
                lat = 5;
            end else begin
                num = {3'd0, ins[11:7]};
                op  = {ins[6:5], 1'b0};
                lat = 4;
            end
            ev = arm_shift(d, num, op, cf);
        end
    endtask

    task automatic check_reset_state();
        check_eq("rst_state", 33'(dbg_state), 33'(IDLE));
        check_eq("rst_in_ready", ifc.in_ready, 1);
        check_eq("rst_out_valid", ifc.out_valid, 0);
        check_eq("rst_rf_port", {ifc.rf_rd_en, ifc.rf_addr}, 0);
        check_eq("rst_shift_data", ifc.shift_data, 0);
        check_eq("rst_shift_num_op_cf", {ifc.shift_num, ifc.shift_op, ifc.shift_cf}, 0);
        check_eq("rst_op2", {ifc.op2_carry, ifc.op2}, 0);
    endtask

    // ---------------- driver ----------------
    // Entered and left at a negedge with the DUT idle
    task automatic run_instr(input logic [31:0] ins, input logic cf, input int stall, input bit poke);
        logic [32:0] exp_v;
        logic [31:0] e_data;
        logic [7:0]  e_num;
        logic [2:0]  e_op;
        logic [4:0]  exp_rf;
        int          lat;
        bit          is_imm;
        bit          is_reg;
        ref_model(ins, cf, exp_v, e_data, e_num, e_op, lat);
        exp_q.push_back(exp_v);
        is_imm = ins[25];
        is_reg = !ins[25] && ins[4];
        check_eq("idle_in_ready", ifc.in_ready, 1);
        ifc.in_valid = 1'b1;
        ifc.instr    = ins;
        ifc.cf_in    = cf;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        ifc.instr    = $urandom;
        ifc.cf_in    = 1'($urandom_range(0, 1));
        for (int c = 1; c < lat; c++) begin
            check_eq("busy_in_ready", ifc.in_ready, 0);
            check_eq("early_out_valid", ifc.out_valid, 0);
            exp_rf = 5'd0;
            if (!is_imm && c == 1) exp_rf = {1'b1, ins[3:0]};
            if (is_reg && c == 2)  exp_rf = {1'b1, ins[11:8]};
            check_eq("rf_port", {ifc.rf_rd_en, ifc.rf_addr}, exp_rf);
            @(negedge clk);
        end
        check_eq("out_valid", ifc.out_valid, 1);
        check_eq("shift_data", ifc.shift_data, e_data);
        check_eq("shift_num", ifc.shift_num, e_num);
        check_eq("shift_op", ifc.shift_op, e_op);
        check_eq("shift_cf", ifc.shift_cf, cf);
        check_eq("op2", {ifc.op2_carry, ifc.op2}, exp_q.pop_front());
        for (int s = 0; s < stall; s++) begin
            if (poke) begin
                ifc.in_valid = 1'b1;
                ifc.instr    = 32'h0200_0000 | 32'($urandom_range(0, 4095));
            end
            @(negedge clk);
            check_eq("stall_op2", {ifc.op2_carry, ifc.op2}, exp_v);
            check_eq("stall_valid_ready", {ifc.out_valid, ifc.in_ready}, 2'b10);
        end
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        ifc.out_ready = 1'b0;
        check_eq("post_hs_valid_ready", {ifc.out_valid, ifc.in_ready}, 2'b01);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ins;
        logic [7:0]  amt_tab[8];
        int          kind;
        amt_tab = '{8'd0, 8'd1, 8'd31, 8'd32, 8'd33, 8'd64, 8'd255, 8'd16};
        for (int i = 0; i < 16; i++) regs[i] = $urandom;
        rst           = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.instr     = 32'd0;
        ifc.cf_in     = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state();
        rst = 1'b0;

        // Rotated immediate 0xFF ror 2
        run_instr(32'h0200_01FF, 1'b0, 0, 0);
        // Immediate with zero rotation keeps the flag
        run_instr(32'h0200_00AB, 1'b1, 0, 0);
        // LSL #4 of r2
        regs[2] = 32'h0000_00F1;
        run_instr(32'h0000_0202, 1'b0, 0, 0);
        // LSL #0 keeps the flag
        run_instr(32'h0000_0002, 1'b1, 0, 0);
        // ASR r3 by r5 (only the low byte of Rs counts)
        regs[3] = 32'h8000_0000;
        regs[5] = 32'h0000_0104;
        run_instr(32'h0000_0553, 1'b0, 0, 0);
        // Register amount of zero keeps the flag
        regs[6] = 32'hFFFF_FF00;
        run_instr(32'h0000_0653, 1'b1, 0, 0);
        // RRX of r1
        regs[1] = 32'h0000_0001;
        run_instr(32'h0000_0061, 1'b1, 0, 0);
        // Backpressure with a competing offer, then the next one goes through
        run_instr(32'h0200_0F80, 1'b0, 3, 1);
        run_instr(32'h0000_0123, 1'b1, 0, 0);

        // Reset while in RD_RS
        regs[7] = 32'h1234_5678;
        regs[8] = 32'h0000_0003;
        ifc.in_valid = 1'b1;
        ifc.instr    = 32'h0000_0817;
        ifc.cf_in    = 1'b1;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_state", 33'(dbg_state), 33'(RD_RS));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        run_instr(32'h0200_0C3C, 1'b1, 0, 0);

        // Randomized mix
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < 16; i++) regs[i] = $urandom;
            ins  = $urandom;
            kind = $urandom_range(0, 2);
            ins[25] = (kind == 0);
            if (kind == 1) begin
                ins[4] = 1'b0;
                if ($urandom_range(0, 3) == 0) ins[11:7] = 5'd0;
            end
            if (kind == 2) begin
                ins[4] = 1'b1;
                regs[ins[11:8]][7:0] = amt_tab[$urandom_range(0, 7)];
            end
            run_instr(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        check_eq("sb_drained", 33'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
